// File: rtl/fir_mac_sched.sv
// 4-tap FIR with one shared 8x8 multiplier, one tap per cycle.
// Handshaked sample in / result out, runtime-writable coefficients.
module fir_mac_sched #(
    parameter logic [7:0] H0 = 8'd5,
    parameter logic [7:0] H1 = 8'd6,
    parameter logic [7:0] H2 = 8'd7,
    parameter logic [7:0] H3 = 8'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  x,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] y,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        coef_we,
    input  logic [1:0]  coef_addr,
    input  logic [7:0]  coef_wdata,
    output logic        busy,
    input  logic        flush
);
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

    state_e      state_q, state_d;
    logic [7:0]  d_q [4];
    logic [7:0]  d_d [4];
    logic [7:0]  h_q [4];
    logic [7:0]  h_d [4];
    logic [15:0] acc_q, acc_d;
    logic [15:0] y_q, y_d;
    logic [1:0]  tap_q, tap_d;
    logic        accept;
    logic [15:0] prod;
    logic [15:0] sum;

    // flush masks in_ready so a flushing cycle can never accept a sample
    assign in_ready  = (state_q == IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign y         = y_q;

    assign prod = {8'd0, h_q[tap_q]} * {8'd0, d_q[tap_q]};
    assign sum  = acc_q + prod;

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        h_d     = h_q;
        acc_d   = acc_q;
        y_d     = y_q;
        tap_d   = tap_q;
        unique case (state_q)
            IDLE: begin
                if (coef_we) h_d[coef_addr] = coef_wdata;
                if (flush) begin
                    d_d = '{default: 8'd0};
                end else if (accept) begin
                    d_d     = '{x, d_q[0], d_q[1], d_q[2]};
                    acc_d   = 16'd0;
                    tap_d   = 2'd0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = sum;
                tap_d = tap_q + 2'd1;
                if (tap_q == 2'd3) begin
                    y_d     = sum;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            d_q     <= '{default: 8'd0};
            h_q     <= '{H0, H1, H2, H3};
            acc_q   <= 16'd0;
            y_q     <= 16'd0;
            tap_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            h_q     <= h_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            tap_q   <= tap_d;
        end
    end
endmodule

// File: tb/tb_fir_mac_sched.sv
// Scoreboard bench for fir_mac_sched: directed cases plus random traffic
// checked against an arithmetic FIR model.
module tb_fir_mac_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  x = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] y;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        coef_we = 1'b0;
    logic [1:0]  coef_addr = 2'd0;
    logic [7:0]  coef_wdata = 8'd0;
    logic        busy;
    logic        flush = 1'b0;

    fir_mac_sched dut (
        .clk(clk), .reset(reset), .x(x), .in_valid(in_valid),
        .in_ready(in_ready), .y(y), .out_valid(out_valid),
        .out_ready(out_ready), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .busy(busy), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] yv;
        int          acc_cyc;
    } exp_t;

    exp_t        sbq [$];
    logic [15:0] outs [$];
    int          nvec = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          mh [4];
    int          hist [4];
    logic        prev_ov = 1'b0;
    logic [15:0] held = 16'd0;
    bit          rnd_or = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic void model_reset();
        mh   = '{5, 6, 7, 8};
        hist = '{0, 0, 0, 0};
        sbq.delete();
    endfunction

    // y[n] = sum h_k * x[n-k], modulo 2^16
    function automatic void model_accept(int xv);
        int s;
        exp_t e;
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = xv;
        s = 0;
        for (int k = 0; k < 4; k++) s += mh[k] * hist[k];
        e.yv = s[15:0];
        e.acc_cyc = cyc + 1;
        sbq.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (out_valid && !prev_ov) begin
                if (sbq.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_out: got y=%0d expected none", y);
                end else begin
                    check("y", y, sbq[0].yv);
                    check("latency", cyc, sbq[0].acc_cyc + 4);
                end
                held = y;
            end else if (out_valid) begin
                check("y_hold", y, held);
            end
            if (out_valid) check("in_ready_out", in_ready, 0);
            if (out_valid && out_ready && sbq.size() > 0) begin
                outs.push_back(y);
                void'(sbq.pop_front());
            end
        end
        prev_ov = out_valid;
    end

    always @(posedge clk) begin
        if (rnd_or) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [7:0] xv, input bit we = 1'b0,
                        input logic [1:0] ad = 2'd0,
                        input logic [7:0] wd = 8'd0);
        bit ok;
        ok = 1'b0;
        x = xv;
        in_valid = 1'b1;
        coef_we = we;
        coef_addr = ad;
        coef_wdata = wd;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin
                if (we) mh[ad] = int'(wd);
                model_accept(int'(xv));
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        coef_we = 1'b0;
        if (!ok) begin
            nvec++;
            nerr++;
            $display("FAIL send_timeout: got no acceptance expected one");
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            nvec++;
            nerr++;
            $display("FAIL drain_timeout: got pending=%0d expected 0", sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] ad, input logic [7:0] wd);
        coef_we = 1'b1;
        coef_addr = ad;
        coef_wdata = wd;
        mh[ad] = int'(wd);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        in_valid = 1'b1;
        x = 8'd77;
        #1;
        check("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        hist = '{0, 0, 0, 0};
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(string nm, input int e [$]);
        check({nm, "_count"}, outs.size(), e.size());
        for (int i = 0; i < e.size() && i < outs.size(); i++)
            check(nm, outs[i], e[i]);
        outs.delete();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        outs.delete();
        send(8'd1);
        repeat (4) send(8'd0);
        drain();
        check_outs("impulse", '{5, 6, 7, 8, 0});

        do_reset();
        repeat (5) send(8'd255);
        drain();
        check_outs("step", '{1275, 2805, 4590, 6630, 6630});

        do_reset();
        for (int k = 0; k < 4; k++) wr(k[1:0], 8'd255);
        repeat (4) send(8'd255);
        drain();
        check("wrap", outs[3], 63492);
        outs.delete();

        // backpressure: output held, samples refused
        do_reset();
        out_ready = 1'b0;
        send(8'd3);
        for (int t = 0; t < 20 && !out_valid; t++) @(posedge clk);
        #1;
        for (int t = 0; t < 10; t++) begin
            in_valid = t[0];
            x = 8'd200;
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_busy", busy, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        send(8'd0);
        drain();
        check_outs("bp", '{15, 18});

        // coefficient write while busy is dropped; flush clears history
        do_reset();
        send(8'd9);
        coef_we = 1'b1;
        coef_addr = 2'd0;
        coef_wdata = 8'd0;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        drain();
        do_flush();
        send(8'd1);
        repeat (3) send(8'd0);
        drain();
        check_outs("flush", '{45, 5, 6, 7, 8});

        // reset during the second MAC cycle
        send(8'd1);
        @(posedge clk);
        #1;
        do_reset();
        send(8'd1);
        repeat (3) send(8'd0);
        drain();
        check_outs("rst_mid", '{5, 6, 7, 8});

        // random traffic with coefficient writes and flushes
        rnd_or = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                drain();
                do_flush();
            end
            if ($urandom_range(0, 3) == 0)
                send(8'($urandom), 1'b1, 2'($urandom), 8'($urandom));
            else
                send(8'($urandom));
        end
        drain();
        rnd_or = 1'b0;
        #2;
        out_ready = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
